// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core.
// This block drives the hold, flush and bubble controls for the PC, IF/ID, ID/EX
// and EX/MEM registers. It covers three cases:
//   - load-use stalls,
//   - multi-cycle ALU (mul/div) stalls,
//   - control flushes on a taken branch or jump.
// EX-stage forwarding is handled elsewhere. This block only resolves the hazards
// that forwarding cannot.
module pipe_hazard_ctrl #(
  parameter int HOLD_TIMEOUT = 64,  // max consecutive BUSY cycles before timeout (>=2)
  parameter int CNT_W        = 16   // width of stall performance counter
) (
  input  logic             sys_clk,
  input  logic             sys_arstn,
  input  logic [4:0]       id_Rs1_i,
  input  logic [4:0]       id_Rs2_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_Rd_i,
  input  logic             ex_MemRead_i,
  input  logic             ex_hold_i,
  input  logic             ex_jump_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_bubble_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Wide enough to hold HOLD_TIMEOUT itself, which is where busy_cnt saturates.
  localparam int BC_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state, state_nxt;
  logic [BC_W-1:0]   busy_cnt, busy_cnt_nxt;
  logic              timeout_set;
  logic              load_use;

  // Load-use hazard detection.
  // A load in EX writes a register that the ID instruction reads. x0 never
  // carries a dependency. rs2 only counts when the ID instruction actually
  // reads it.
  always_comb begin
    load_use = ex_MemRead_i && (ex_Rd_i != 5'd0) &&
               ((ex_Rd_i == id_Rs1_i) || (id_use_rs2_i && (ex_Rd_i == id_Rs2_i)));
  end

  // Next-state logic and control outputs.
  // Priority in IDLE is ALU hold > jump > load-use. Holds and flushes for the
  // same register are never raised together.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    pc_hold_o       = 1'b0;
    if_id_hold_o    = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_hold_o    = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_bubble_o = 1'b0;
    state_nxt       = state;
    busy_cnt_nxt    = busy_cnt;
    timeout_set     = 1'b0;

    case (state)
      IDLE: begin
        if (ex_hold_i) begin
          pc_hold_o       = 1'b1;
          if_id_hold_o    = 1'b1;
          id_ex_hold_o    = 1'b1;
          ex_mem_bubble_o = 1'b1;
          state_nxt       = BUSY;
          busy_cnt_nxt    = BC_W'(1);
        end else if (ex_jump_i) begin
          // Discard the two wrong-path instructions fetched behind the branch.
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (load_use) begin
          // One bubble lets the load reach MEM, where forwarding picks it up.
          pc_hold_o     = 1'b1;
          if_id_hold_o  = 1'b1;
          id_ex_flush_o = 1'b1;
        end
      end

      BUSY: begin
        if (ex_hold_i) begin
          pc_hold_o       = 1'b1;
          if_id_hold_o    = 1'b1;
          id_ex_hold_o    = 1'b1;
          ex_mem_bubble_o = 1'b1;
          if (busy_cnt != BC_W'(HOLD_TIMEOUT)) busy_cnt_nxt = busy_cnt + BC_W'(1);
          if (busy_cnt == BC_W'(HOLD_TIMEOUT - 1)) timeout_set = 1'b1;
        end else begin
          // Result is valid this cycle: let EX/MEM capture it.
          // Jump and load-use are ignored here, because a mul/div cannot be a
          // jump and ID was frozen behind it.
          state_nxt    = IDLE;
          busy_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt    = IDLE;
        busy_cnt_nxt = '0;
      end
    endcase
  end

  // State register, busy counter and sticky timeout flag.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      if (timeout_set) timeout_o <= 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      stall_cnt_o <= '0;
    end else if (pc_hold_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// The bench checks the IDLE-state decode with a vector table. Hand-written
// sequences then check:
//   - ALU hold and release,
//   - the sticky timeout,
//   - reset asserted in the middle of BUSY,
//   - stall counter saturation on a narrow-counter instance.
module tb_pipe_hazard_ctrl;

  logic        sys_clk;
  logic        sys_arstn;
  logic [4:0]  id_Rs1_i;
  logic [4:0]  id_Rs2_i;
  logic        id_use_rs2_i;
  logic [4:0]  ex_Rd_i;
  logic        ex_MemRead_i;
  logic        ex_hold_i;
  logic        ex_jump_i;

  logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_bubble;
  logic        timeout;
  logic [15:0] stall_cnt;

  logic        pc_hold4, if_id_hold4, if_id_flush4, id_ex_hold4, id_ex_flush4, ex_mem_bubble4;
  logic        timeout4;
  logic [3:0]  stall_cnt4;

  // Control bundle order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_bubble}
  logic [5:0]  ctrl, ctrl4;
  assign ctrl  = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_bubble};
  assign ctrl4 = {pc_hold4, if_id_hold4, if_id_flush4, id_ex_hold4, id_ex_flush4, ex_mem_bubble4};

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_HOLD  = 6'b110101;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_FLUSH = 6'b001010;

  pipe_hazard_ctrl #(.HOLD_TIMEOUT(64), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn),
    .id_Rs1_i(id_Rs1_i), .id_Rs2_i(id_Rs2_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_Rd_i(ex_Rd_i), .ex_MemRead_i(ex_MemRead_i),
    .ex_hold_i(ex_hold_i), .ex_jump_i(ex_jump_i),
    .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold), .if_id_flush_o(if_id_flush),
    .id_ex_hold_o(id_ex_hold), .id_ex_flush_o(id_ex_flush),
    .ex_mem_bubble_o(ex_mem_bubble), .timeout_o(timeout), .stall_cnt_o(stall_cnt)
  );

  pipe_hazard_ctrl #(.HOLD_TIMEOUT(64), .CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn),
    .id_Rs1_i(id_Rs1_i), .id_Rs2_i(id_Rs2_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_Rd_i(ex_Rd_i), .ex_MemRead_i(ex_MemRead_i),
    .ex_hold_i(ex_hold_i), .ex_jump_i(ex_jump_i),
    .pc_hold_o(pc_hold4), .if_id_hold_o(if_id_hold4), .if_id_flush_o(if_id_flush4),
    .id_ex_hold_o(id_ex_hold4), .id_ex_flush_o(id_ex_flush4),
    .ex_mem_bubble_o(ex_mem_bubble4), .timeout_o(timeout4), .stall_cnt_o(stall_cnt4)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_Rs1_i     = 5'd0;
    id_Rs2_i     = 5'd0;
    id_use_rs2_i = 1'b0;
    ex_Rd_i      = 5'd0;
    ex_MemRead_i = 1'b0;
    ex_hold_i    = 1'b0;
    ex_jump_i    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_arstn = 1'b0;
    tick();
    tick();
    sys_arstn = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs2;
    logic [4:0] rd;
    logic       mem_read;
    logic       jump;
    logic [5:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];
  int   exp_stall;

  initial begin
    vecs[0] = '{"all_zero",      5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 1'b0, C_NONE};
    vecs[1] = '{"lw_x5_add_x5",  5'd5,  5'd1, 1'b1, 5'd5,  1'b1, 1'b0, C_LU};
    vecs[2] = '{"after_lu",      5'd5,  5'd1, 1'b1, 5'd0,  1'b0, 1'b0, C_NONE};
    vecs[3] = '{"lw_x0",         5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 1'b0, C_NONE};
    vecs[4] = '{"rs2_unused",    5'd2,  5'd5, 1'b0, 5'd5,  1'b1, 1'b0, C_NONE};
    vecs[5] = '{"rs2_used",      5'd2,  5'd5, 1'b1, 5'd5,  1'b1, 1'b0, C_LU};
    vecs[6] = '{"match_no_load", 5'd5,  5'd0, 1'b0, 5'd5,  1'b0, 1'b0, C_NONE};
    vecs[7] = '{"jump_over_lu",  5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b1, C_FLUSH};
    vecs[8] = '{"jump_only",     5'd3,  5'd4, 1'b1, 5'd7,  1'b0, 1'b1, C_FLUSH};
    vecs[9] = '{"lu_x31",        5'd31, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, C_LU};

    clear_inputs();
    sys_arstn = 1'b0;
    #12;
    check("reset_ctrl",      32'(ctrl),      32'(C_NONE));
    check("reset_timeout",   32'(timeout),   32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    sys_arstn = 1'b1;

    // IDLE decode table.
    exp_stall = 0;
    for (int i = 0; i < 10; i++) begin
      id_Rs1_i     = vecs[i].rs1;
      id_Rs2_i     = vecs[i].rs2;
      id_use_rs2_i = vecs[i].use_rs2;
      ex_Rd_i      = vecs[i].rd;
      ex_MemRead_i = vecs[i].mem_read;
      ex_jump_i    = vecs[i].jump;
      #2;
      check(vecs[i].name, 32'(ctrl), 32'(vecs[i].exp_ctrl));
      if (vecs[i].exp_ctrl[5]) exp_stall++;
      tick();
    end
    clear_inputs();
    #2;
    check("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // ALU hold for 33 cycles. The first cycle also presents a jump and a
    // load-use, and hold must win over both.
    id_Rs1_i = 5'd5; ex_Rd_i = 5'd5; ex_MemRead_i = 1'b1;
    ex_hold_i = 1'b1; ex_jump_i = 1'b1;
    #2;
    check("hold_priority", 32'(ctrl), 32'(C_HOLD));
    tick();
    ex_jump_i = 1'b0;
    for (int k = 2; k <= 33; k++) begin
      #2;
      check($sformatf("busy_hold_%0d", k), 32'(ctrl), 32'(C_HOLD));
      tick();
    end
    // Release cycle: jump and load-use present but ignored.
    ex_hold_i = 1'b0; ex_jump_i = 1'b1;
    #2;
    check("busy_release", 32'(ctrl), 32'(C_NONE));
    tick();
    #2;
    check("idle_after_release", 32'(ctrl),      32'(C_FLUSH));
    check("stall_after_hold",   32'(stall_cnt), 32'(exp_stall + 33));
    check("no_timeout_33",      32'(timeout),   32'd0);
    ex_jump_i = 1'b0;
    #1;
    check("lu_after_release", 32'(ctrl), 32'(C_LU));
    tick();
    clear_inputs();
    #2;
    check("stall_after_lu", 32'(stall_cnt), 32'(exp_stall + 34));

    // Hold for 70 cycles with HOLD_TIMEOUT=64.
    do_reset();
    ex_hold_i = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 63) check("timeout_before", 32'(timeout), 32'd0);
      if (k == 64) check("timeout_rise",   32'(timeout), 32'd1);
    end
    #2;
    check("hold_saturated_busy", 32'(ctrl), 32'(C_HOLD));
    ex_hold_i = 1'b0;
    #1;
    check("release_70", 32'(ctrl), 32'(C_NONE));
    tick();
    check("timeout_sticky", 32'(timeout),   32'd1);
    check("stall_70",       32'(stall_cnt), 32'd70);

    // Reset asserted in the middle of BUSY.
    ex_hold_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    ex_hold_i = 1'b0; ex_jump_i = 1'b1;
    sys_arstn = 1'b0;
    #1;
    check("midbusy_rst_idle",    32'(ctrl),      32'(C_FLUSH));
    check("midbusy_rst_timeout", 32'(timeout),   32'd0);
    check("midbusy_rst_stall",   32'(stall_cnt), 32'd0);
    tick();
    sys_arstn = 1'b1;

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    ex_hold_i = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    ex_hold_i = 1'b0;
    tick();
    #2;
    check("stall4_saturate", 32'(stall_cnt4), 32'd15);
    check("stall16_20",      32'(stall_cnt),  32'd20);
    check("dut4_ctrl_idle",  32'(ctrl4),      32'(C_NONE));
    check("dut4_no_timeout", 32'(timeout4),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
